// File: rtl/irq_vec_ctrl.sv
// Core-local interrupt/exception controller: latches edge-triggered IRQs and ECALL/EBREAK/MRET,
// sequences the mepc/mcause/mstatus writes and redirects fetch to the direct or vectored mtvec.
module irq_vec_ctrl #(
    parameter int unsigned NUM_IRQ = 4,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] irq_en_i,
    input  logic [31:0]        inst_i,
    input  logic [ADDR_W-1:0]  inst_addr_i,
    input  logic               jump_flag_i,
    input  logic [ADDR_W-1:0]  jump_addr_i,
    input  logic               div_busy_i,
    input  logic [31:0]        csr_mtvec_i,
    input  logic [31:0]        csr_mepc_i,
    input  logic [31:0]        csr_mstatus_i,
    output logic [2:0]         hold_flag_o,
    output logic               csr_we_o,
    output logic [11:0]        csr_waddr_o,
    output logic [31:0]        csr_wdata_o,
    output logic               int_assert_o,
    output logic [ADDR_W-1:0]  int_addr_o,
    output logic [NUM_IRQ-1:0] irq_ack_o
);

    localparam logic [2:0]  PipeFlow   = 3'b000;
    localparam logic [2:0]  PipeClear  = 3'b100;
    localparam logic [31:0] InstEcall  = 32'h0000_0073;
    localparam logic [31:0] InstEbreak = 32'h0010_0073;
    localparam logic [31:0] InstMret   = 32'h3020_0073;
    localparam logic [11:0] CsrMstatus = 12'h300;
    localparam logic [11:0] CsrMepc    = 12'h341;
    localparam logic [11:0] CsrMcause  = 12'h342;
    localparam int unsigned IdxW       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [2:0] {
        StIdle, StMepc, StMcause, StMstat, StJump, StRMstat, StRJump
    } state_e;

    state_e               state_q;
    logic [NUM_IRQ-1:0]   pending_q, pending_d, prev_irq_q;
    logic [31:0]          cause_q, mstatus_q;
    logic                 csr_we_q, int_assert_q;
    logic [11:0]          csr_waddr_q;
    logic [31:0]          csr_wdata_q;
    logic [ADDR_W-1:0]    int_addr_q;

    logic                 is_ecall, is_ebreak, is_mret, is_idle, irq_found;
    logic                 take_sync, take_mret, take_irq;
    logic [IdxW-1:0]      irq_idx;
    logic [31:0]          sync_cause, irq_cause, trap_mstatus, mret_mstatus;
    logic [ADDR_W-1:0]    irq_mepc, mtvec_base, vec_offset;

    always_comb begin
        is_ecall  = (inst_i == InstEcall);
        is_ebreak = (inst_i == InstEbreak);
        is_mret   = (inst_i == InstMret);
        is_idle   = (state_q == StIdle) && !rst;

        // Descending scan so the lowest enabled pending source wins.
        irq_found = 1'b0;
        irq_idx   = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (pending_q[k] && irq_en_i[k]) begin
                irq_found = 1'b1;
                irq_idx   = IdxW'(k);
            end
        end

        take_sync = is_idle && (is_ecall || is_ebreak);
        take_mret = is_idle && !is_ecall && !is_ebreak && is_mret;
        take_irq  = is_idle && !is_ecall && !is_ebreak && !is_mret && irq_found
                    && csr_mstatus_i[3] && !div_busy_i;

        sync_cause   = is_ecall ? 32'd11 : 32'd3;
        irq_cause    = 32'h8000_0000 | (32'd16 + 32'(irq_idx));
        irq_mepc     = jump_flag_i ? jump_addr_i : inst_addr_i;
        trap_mstatus = {mstatus_q[31:8], mstatus_q[3], mstatus_q[6:4], 1'b0, mstatus_q[2:0]};
        mret_mstatus = {csr_mstatus_i[31:8], 1'b1, csr_mstatus_i[6:4], csr_mstatus_i[7],
                        csr_mstatus_i[2:0]};

        irq_ack_o = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            irq_ack_o[k] = take_irq && (irq_idx == IdxW'(k));
        end

        // A new edge in the clearing cycle must survive.
        pending_d = (pending_q & ~irq_ack_o) | (irq_i & ~prev_irq_q);

        hold_flag_o = (take_sync || take_mret || take_irq || (state_q != StIdle && !rst))
                      ? PipeClear : PipeFlow;

        mtvec_base = ADDR_W'(csr_mtvec_i & ~32'h3);
        vec_offset = ADDR_W'({cause_q[4:0], 2'b00});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            pending_q    <= '0;
            prev_irq_q   <= irq_i;
            cause_q      <= '0;
            mstatus_q    <= '0;
            csr_we_q     <= 1'b0;
            csr_waddr_q  <= '0;
            csr_wdata_q  <= '0;
            int_assert_q <= 1'b0;
            int_addr_q   <= '0;
        end else begin
            prev_irq_q   <= irq_i;
            pending_q    <= pending_d;
            csr_we_q     <= 1'b0;
            csr_waddr_q  <= '0;
            csr_wdata_q  <= '0;
            int_assert_q <= 1'b0;
            int_addr_q   <= '0;
            unique case (state_q)
                StIdle: begin
                    if (take_sync || take_irq) begin
                        state_q     <= StMepc;
                        cause_q     <= take_sync ? sync_cause : irq_cause;
                        mstatus_q   <= csr_mstatus_i;
                        csr_we_q    <= 1'b1;
                        csr_waddr_q <= CsrMepc;
                        csr_wdata_q <= 32'(take_sync ? inst_addr_i : irq_mepc);
                    end else if (take_mret) begin
                        state_q     <= StRMstat;
                        csr_we_q    <= 1'b1;
                        csr_waddr_q <= CsrMstatus;
                        csr_wdata_q <= mret_mstatus;
                    end
                end
                StMepc: begin
                    state_q     <= StMcause;
                    csr_we_q    <= 1'b1;
                    csr_waddr_q <= CsrMcause;
                    csr_wdata_q <= cause_q;
                end
                StMcause: begin
                    state_q     <= StMstat;
                    csr_we_q    <= 1'b1;
                    csr_waddr_q <= CsrMstatus;
                    csr_wdata_q <= trap_mstatus;
                end
                StMstat: begin
                    state_q      <= StJump;
                    int_assert_q <= 1'b1;
                    // Only async causes use the vector table; sync traps go to the base.
                    int_addr_q   <= (cause_q[31] && csr_mtvec_i[1:0] == 2'b01)
                                    ? mtvec_base + vec_offset : mtvec_base;
                end
                StJump:   state_q <= StIdle;
                StRMstat: begin
                    state_q      <= StRJump;
                    int_assert_q <= 1'b1;
                    int_addr_q   <= ADDR_W'(csr_mepc_i);
                end
                StRJump:  state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

    assign csr_we_o     = csr_we_q;
    assign csr_waddr_o  = csr_waddr_q;
    assign csr_wdata_o  = csr_wdata_q;
    assign int_assert_o = int_assert_q;
    assign int_addr_o   = int_addr_q;

endmodule

// File: tb/tb_irq_vec_ctrl.sv
// Scoreboard bench for irq_vec_ctrl: expected acks, CSR writes and redirects are queued as
// stimulus is applied and compared in order (with latency) as the DUT emits them.
module tb_irq_vec_ctrl;

    localparam int unsigned NUM_IRQ = 4;
    localparam int unsigned ADDR_W  = 32;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_IRQ-1:0] irq_i, irq_en_i, irq_ack_o;
    logic [31:0]        inst_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i, csr_wdata_o;
    logic [ADDR_W-1:0]  inst_addr_i, jump_addr_i, int_addr_o;
    logic               jump_flag_i, div_busy_i, csr_we_o, int_assert_o;
    logic [2:0]         hold_flag_o;
    logic [11:0]        csr_waddr_o;

    irq_vec_ctrl #(.NUM_IRQ(NUM_IRQ), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .irq_i(irq_i), .irq_en_i(irq_en_i), .inst_i(inst_i),
        .inst_addr_i(inst_addr_i), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .div_busy_i(div_busy_i), .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i),
        .csr_mstatus_i(csr_mstatus_i), .hold_flag_o(hold_flag_o), .csr_we_o(csr_we_o),
        .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o), .int_assert_o(int_assert_o),
        .int_addr_o(int_addr_o), .irq_ack_o(irq_ack_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          kind;   // 0 ack, 1 csr write, 2 redirect
        logic [11:0] addr;
        logic [31:0] data;
        int          dly;    // cycles after previous event, 0 = unchecked
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   mon_cyc  = 0;
    int   mon_last = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic sb_push(input string tag, input int kind, input logic [11:0] addr,
                           input logic [31:0] data, input int dly);
        exp_t e;
        e.tag = tag; e.kind = kind; e.addr = addr; e.data = data; e.dly = dly;
        exp_q.push_back(e);
    endtask

    task automatic exp_ack(input string tag, input int k, input int dly);
        sb_push({tag, "_ack"}, 0, 12'h0, 32'(1 << k), dly);
    endtask

    task automatic exp_trap(input string tag, input logic [31:0] mepc, input logic [31:0] cause,
                            input logic [31:0] mst, input logic [31:0] jaddr, input int dly);
        sb_push({tag, "_mepc"}, 1, 12'h341, mepc, dly);
        sb_push({tag, "_mcause"}, 1, 12'h342, cause, 1);
        sb_push({tag, "_mstatus"}, 1, 12'h300, mst, 1);
        sb_push({tag, "_jump"}, 2, 12'h0, jaddr, 1);
    endtask

    task automatic exp_mret(input string tag, input logic [31:0] mst, input logic [31:0] jaddr);
        sb_push({tag, "_mstatus"}, 1, 12'h300, mst, 0);
        sb_push({tag, "_jump"}, 2, 12'h0, jaddr, 1);
    endtask

    task automatic sb_pop(input int kind, input logic [11:0] addr, input logic [31:0] data);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq("unexpected_event", 64'(kind), 64'hF);
        end else begin
            e = exp_q.pop_front();
            check_eq({e.tag, "_kind"}, 64'(kind), 64'(e.kind));
            if (kind == 1) check_eq({e.tag, "_addr"}, 64'(addr), 64'(e.addr));
            check_eq({e.tag, "_data"}, 64'(data), 64'(e.data));
            if (e.dly != 0) check_eq({e.tag, "_lat"}, 64'(mon_cyc - mon_last), 64'(e.dly));
            check_eq({e.tag, "_hold"}, 64'(hold_flag_o), 64'h4);
        end
        mon_last = mon_cyc;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (irq_ack_o != '0) sb_pop(0, 12'h0, 32'(irq_ack_o));
            if (csr_we_o)        sb_pop(1, csr_waddr_o, csr_wdata_o);
            if (int_assert_o)    sb_pop(2, 12'h0, 32'(int_addr_o));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_drain(input string tag, input int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) step(1);
        check_eq({tag, "_drain"}, 64'(exp_q.size()), 64'h0);
        step(2);
    endtask

    task automatic check_quiet(input string tag, input int n);
        repeat (n) begin
            @(negedge clk);
            check_eq({tag, "_no_ack"}, 64'(irq_ack_o), 64'h0);
            check_eq({tag, "_flow"}, 64'(hold_flag_o), 64'h0);
        end
        step(1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_hold"}, 64'(hold_flag_o), 64'h0);
        check_eq({tag, "_we"}, 64'(csr_we_o), 64'h0);
        check_eq({tag, "_waddr"}, 64'(csr_waddr_o), 64'h0);
        check_eq({tag, "_wdata"}, 64'(csr_wdata_o), 64'h0);
        check_eq({tag, "_assert"}, 64'(int_assert_o), 64'h0);
        check_eq({tag, "_addr"}, 64'(int_addr_o), 64'h0);
        check_eq({tag, "_ack"}, 64'(irq_ack_o), 64'h0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic found;
        rst = 1'b1; irq_i = '0; irq_en_i = '0; inst_i = NOP; inst_addr_i = 32'h1000;
        jump_flag_i = 1'b0; jump_addr_i = '0; div_busy_i = 1'b0;
        csr_mtvec_i = 32'h100; csr_mepc_i = '0; csr_mstatus_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #2;
        rst = 1'b0;

        // 1. Direct async interrupt on source 0.
        irq_en_i = 4'hF; csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h100;
        exp_ack("t1", 0, 0);
        exp_trap("t1", 32'h1000, 32'h8000_0010, 32'h80, 32'h100, 1);
        irq_i = 4'h1; step(1); irq_i = '0;
        wait_drain("t1", 20);

        // 2. Vectored: k=1 before k=2, then MRET and k=2 with jump_flag mepc.
        csr_mtvec_i = 32'h201; csr_mstatus_i = 32'h8;
        exp_ack("t2a", 1, 0);
        exp_trap("t2a", 32'h1000, 32'h8000_0011, 32'h80, 32'h244, 1);
        irq_i = 4'h6; step(1); irq_i = '0; step(1);
        csr_mstatus_i = 32'h80; csr_mepc_i = 32'h1000;
        wait_drain("t2a", 20);
        exp_mret("t2r", 32'h88, 32'h1000);
        exp_ack("t2b", 2, 1);
        exp_trap("t2b", 32'h2000, 32'h8000_0012, 32'h80, 32'h248, 1);
        inst_i = MRET; inst_addr_i = 32'h244; step(1);
        inst_i = NOP; inst_addr_i = 32'h1000; jump_flag_i = 1'b1; jump_addr_i = 32'h2000;
        csr_mstatus_i = 32'h88;
        wait_drain("t2b", 20);
        jump_flag_i = 1'b0; csr_mstatus_i = '0;

        // 3. ECALL beats a pending irq[0]; irq[0] taken right after return.
        csr_mtvec_i = 32'h201;
        irq_i = 4'h1; step(1); irq_i = '0; step(2);
        exp_trap("t3e", 32'h80, 32'd11, 32'h80, 32'h200, 0);
        exp_ack("t3i", 0, 1);
        exp_trap("t3i", 32'h84, 32'h8000_0010, 32'h80, 32'h240, 1);
        inst_i = ECALL; inst_addr_i = 32'h80; csr_mstatus_i = 32'h8; step(1);
        inst_i = NOP; inst_addr_i = 32'h84;
        wait_drain("t3", 30);
        csr_mstatus_i = '0;

        // EBREAK ignores MIE=0 and div_busy.
        csr_mtvec_i = 32'h100; div_busy_i = 1'b1;
        exp_trap("t3b", 32'h90, 32'd3, 32'h0, 32'h100, 0);
        inst_i = EBREAK; inst_addr_i = 32'h90; step(1);
        inst_i = NOP; inst_addr_i = 32'h1000; div_busy_i = 1'b0;
        wait_drain("t3b", 20);

        // 4. Masking by MIE then by div_busy.
        irq_i = 4'h8; step(1); irq_i = '0;
        check_quiet("t4mie", 4);
        csr_mstatus_i = 32'h8; div_busy_i = 1'b1;
        check_quiet("t4div", 3);
        exp_ack("t4", 3, 0);
        exp_trap("t4", 32'h1000, 32'h8000_0013, 32'h80, 32'h100, 1);
        div_busy_i = 1'b0;
        wait_drain("t4", 20);

        // 5. MRET restores MIE from MPIE and returns to mepc.
        csr_mstatus_i = 32'h80; csr_mepc_i = 32'h400;
        exp_mret("t5", 32'h88, 32'h400);
        inst_i = MRET; inst_addr_i = 32'h500;
        @(negedge clk);
        check_eq("t5_accept_hold", 64'(hold_flag_o), 64'h4);
        check_eq("t5_accept_noack", 64'(irq_ack_o), 64'h0);
        step(1);
        inst_i = NOP; inst_addr_i = 32'h1000;
        wait_drain("t5", 20);

        // 6. Reset while in S_MCAUSE aborts the sequence and clears pending.
        csr_mstatus_i = 32'h8;
        exp_ack("t6a", 0, 0);
        sb_push("t6a_mepc", 1, 12'h341, 32'h1000, 1);
        sb_push("t6a_mcause", 1, 12'h342, 32'h8000_0010, 1);
        irq_i = 4'h1; step(1); irq_i = 4'h2;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (csr_we_o && csr_waddr_o == 12'h342) found = 1'b1;
        end
        check_eq("t6_reach_mcause", 64'(found), 64'h1);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_outputs_zero("t6_rst");
        @(posedge clk); #2;
        rst = 1'b0;
        check_quiet("t6_cleared", 4);
        exp_ack("t6b", 3, 0);
        exp_trap("t6b", 32'h1000, 32'h8000_0013, 32'h80, 32'h100, 1);
        irq_i = 4'hA; step(1);
        wait_drain("t6b", 20);
        irq_i = '0; csr_mstatus_i = '0;
        step(3);
        check_eq("final_queue_empty", 64'(exp_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
